// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage producer. Issues in-order fetch requests to
//   instruction memory, buffers the returned words in a small in-order queue
//   and presents the head entry (pc_o / inst_o) to the IF/ID register.
//   A branch redirect flushes the queue and arranges for responses that are
//   still in flight to be discarded when they arrive.
//
// Optional feature macro: FETCH_PERF_EN
//   defined     -> perf_stall_o counts cycles with valid_o && stall_i,
//                  perf_drop_o counts discarded responses; both saturate.
//   not defined -> no counters; perf_stall_o / perf_drop_o tied to 0.
//
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   stall_i          IF/ID is holding; the head entry is not consumed
//   redirect_i       discard all fetched / in-flight work, restart fetch
//   redirect_pc_i    restart address (bits [1:0] ignored)
//   imem_req_o       fetch request, imem_addr_o its address
//   imem_gnt_i       request accepted this cycle
//   imem_rvalid_i    in-order response valid, imem_rdata_i its data
//   valid_o          head entry holds a returned instruction
//   pc_o, inst_o     head pc / instruction (0 / NOP_INST when !valid_o)
//   perf_stall_o     stall cycle counter
//   perf_drop_o      dropped response counter
//
// Handshake: a request transfers on a cycle where imem_req_o && imem_gnt_i.
//   Once imem_req_o is raised it stays high with imem_addr_o unchanged until
//   that transfer, unless reset or redirect withdraws it. The response comes
//   back on imem_rvalid_i at least one cycle later, in request order, and is
//   always accepted (there is no back-pressure on the response channel).
//   On the IF/ID side, the head is consumed on a cycle where
//   valid_o && !stall_i.
// -----------------------------------------------------------------------------
module if_fetch_unit #(
   parameter int unsigned      Width      = 32,
   parameter logic [Width-1:0] RESET_PC   = '0,
   parameter int unsigned      FIFO_DEPTH = 2,
   parameter logic [Width-1:0] NOP_INST   = Width'(32'h0000_0013)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             stall_i,
   input  logic             redirect_i,
   input  logic [Width-1:0] redirect_pc_i,
   output logic             imem_req_o,
   output logic [Width-1:0] imem_addr_o,
   input  logic             imem_gnt_i,
   input  logic             imem_rvalid_i,
   input  logic [Width-1:0] imem_rdata_i,
   output logic             valid_o,
   output logic [Width-1:0] pc_o,
   output logic [Width-1:0] inst_o,
   output logic [31:0]      perf_stall_o,
   output logic [31:0]      perf_drop_o
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   // Drop counter: each redirect adds at most FIFO_DEPTH in-flight responses.
   localparam int unsigned DW = 8;

   typedef logic [PW-1:0] ptr_t;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(FIFO_DEPTH - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   // Queue storage: pc captured on grant, instruction captured on fill.
   logic [Width-1:0]      r_pc     [FIFO_DEPTH];
   logic [Width-1:0]      r_inst   [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] r_filled;

   ptr_t                  r_alloc_ptr;
   ptr_t                  r_fill_ptr;
   ptr_t                  r_head_ptr;
   logic [CW-1:0]         r_alloc_cnt;   // entries allocated and not yet popped
   logic [CW-1:0]         r_pend_cnt;    // allocated entries still awaiting data
   logic [DW-1:0]         r_drop_cnt;    // in-flight responses to discard
   logic [Width-1:0]      r_fetch_pc;

   logic                  w_req;
   logic                  w_grant;
   logic                  w_rsp_drop;
   logic                  w_rsp_fill;
   logic                  w_valid;
   logic                  w_pop;
   logic [DW-1:0]         w_redirect_drop;
   logic                  w_unused;

   assign w_req      = !rst_i && !redirect_i && (r_alloc_cnt < CW'(FIFO_DEPTH));
   assign w_grant    = w_req && imem_gnt_i;
   assign w_rsp_drop = imem_rvalid_i && (r_drop_cnt != '0);
   assign w_rsp_fill = imem_rvalid_i && (r_drop_cnt == '0) && (r_pend_cnt != '0);
   assign w_valid    = r_filled[r_head_ptr] && !redirect_i && !rst_i;
   assign w_pop      = w_valid && !stall_i;

   // Everything still in flight at redirect must be discarded later; a
   // response arriving in the redirect cycle itself already consumes one.
   assign w_redirect_drop = r_drop_cnt + DW'(r_pend_cnt) - DW'(w_rsp_drop || w_rsp_fill);

   // Fetch addresses are word aligned, so the low redirect bits are unused.
   assign w_unused = ^redirect_pc_i[1:0];

   assign imem_req_o  = w_req;
   assign imem_addr_o = r_fetch_pc;
   assign valid_o     = w_valid;
   assign pc_o        = w_valid ? r_pc[r_head_ptr]   : '0;
   assign inst_o      = w_valid ? r_inst[r_head_ptr] : NOP_INST;

   // Control state
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_fetch_pc  <= RESET_PC;
         r_alloc_ptr <= '0;
         r_fill_ptr  <= '0;
         r_head_ptr  <= '0;
         r_alloc_cnt <= '0;
         r_pend_cnt  <= '0;
         r_drop_cnt  <= '0;
         r_filled    <= '0;
      end else if (redirect_i) begin
         r_fetch_pc  <= {redirect_pc_i[Width-1:2], 2'b00};
         r_alloc_ptr <= '0;
         r_fill_ptr  <= '0;
         r_head_ptr  <= '0;
         r_alloc_cnt <= '0;
         r_pend_cnt  <= '0;
         r_drop_cnt  <= w_redirect_drop;
         r_filled    <= '0;
      end else begin
         if (w_grant) begin
            r_alloc_ptr <= ptr_inc(r_alloc_ptr);
            r_fetch_pc  <= r_fetch_pc + Width'(4);
         end
         if (w_rsp_fill) begin
            r_filled[r_fill_ptr] <= 1'b1;
            r_fill_ptr           <= ptr_inc(r_fill_ptr);
         end
         if (w_rsp_drop) begin
            r_drop_cnt <= r_drop_cnt - DW'(1);
         end
         // Fill and pop never hit the same entry: fill targets an unfilled
         // entry, pop only a filled one.
         if (w_pop) begin
            r_filled[r_head_ptr] <= 1'b0;
            r_head_ptr           <= ptr_inc(r_head_ptr);
         end
         r_alloc_cnt <= r_alloc_cnt + CW'(w_grant) - CW'(w_pop);
         r_pend_cnt  <= r_pend_cnt + CW'(w_grant) - CW'(w_rsp_fill);
      end
   end

   // Payload storage; validity is tracked by r_filled, so no reset needed.
   always_ff @(posedge clk_i) begin
      if (w_grant) begin
         r_pc[r_alloc_ptr] <= r_fetch_pc;
      end
      if (w_rsp_fill && !redirect_i) begin
         r_inst[r_fill_ptr] <= imem_rdata_i;
      end
   end

   // A response with nothing outstanding is ignored above; flag it in sim.
   always_ff @(posedge clk_i) begin
      if (!rst_i && imem_rvalid_i) begin
         assert ((r_drop_cnt != '0) || (r_pend_cnt != '0));
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_drop;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_perf_stall <= '0;
         r_perf_drop  <= '0;
      end else begin
         if (w_valid && stall_i && (r_perf_stall != 32'hFFFF_FFFF)) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
         if (w_rsp_drop && (r_perf_drop != 32'hFFFF_FFFF)) begin
            r_perf_drop <= r_perf_drop + 32'd1;
         end
      end
   end

   assign perf_stall_o = r_perf_stall;
   assign perf_drop_o  = r_perf_drop;
`else
   assign perf_stall_o = '0;
   assign perf_drop_o  = '0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
//   Directed bench for if_fetch_unit (default parameters, FIFO_DEPTH=2).
//   Memory model: mem[a] = a ^ 32'hA5A5_0000, response one cycle after grant
//   while rsp_en is set. Inputs change 1 ns after the rising edge, outputs
//   are sampled on the falling edge. The cycle comments Cn give the expected
//   queue behaviour that the hand-computed values come from.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] MK  = 32'hA5A5_0000;
`ifdef FETCH_PERF_EN
   localparam logic [31:0] EXP_STALL = 32'd2;
   localparam logic [31:0] EXP_DROP  = 32'd2;
`else
   localparam logic [31:0] EXP_STALL = 32'd0;
   localparam logic [31:0] EXP_DROP  = 32'd0;
`endif

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        stall_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;
   logic        valid_o;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic [31:0] perf_stall_o;
   logic [31:0] perf_drop_o;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   logic [31:0] exp_q[$];   // expected pc stream of consumed instructions
   logic [31:0] got_q[$];
   logic [31:0] rsp_q[$];   // granted addresses awaiting response
   logic        will_grant = 1'b0;
   logic [31:0] grant_addr = '0;
   logic        rsp_en = 1'b1;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   if_fetch_unit dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .valid_o       (valid_o),
      .pc_o          (pc_o),
      .inst_o        (inst_o),
      .perf_stall_o  (perf_stall_o),
      .perf_drop_o   (perf_drop_o)
   );

   // ---------------- memory responder ----------------
   always @(negedge clk) begin
      will_grant = imem_req_o && imem_gnt_i;
      grant_addr = imem_addr_o;
      if (rst_i) begin
         will_grant = 1'b0;
         rsp_q.delete();
      end
   end

   always @(posedge clk) begin
      #2;
      if (will_grant) rsp_q.push_back(grant_addr);
      if (rsp_en && rsp_q.size() > 0) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = rsp_q.pop_front() ^ MK;
      end else begin
         imem_rvalid_i = 1'b0;
         imem_rdata_i  = '0;
      end
   end

   // ---------------- consumed-stream monitor ----------------
   always @(negedge clk) begin
      if (!rst_i && valid_o && !stall_i) got_q.push_back(pc_o);
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_head(input string tag, input logic [31:0] pc);
      chk({tag, "_valid"}, 32'(valid_o), 32'd1);
      chk({tag, "_pc"}, pc_o, pc);
      chk({tag, "_inst"}, inst_o, pc ^ MK);
   endtask

   task automatic chk_bubble(input string tag);
      chk({tag, "_valid"}, 32'(valid_o), 32'd0);
      chk({tag, "_pc"}, pc_o, 32'd0);
      chk({tag, "_inst"}, inst_o, NOP);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C,
                32'h0, 32'h4, 32'h100, 32'hFFFF_FFFC, 32'h0};

      // Reset
      cyc(); cyc(); mid();
      chk("rst_req", 32'(imem_req_o), 32'd0);
      chk_bubble("rst");
      chk("rst_perf_stall", perf_stall_o, 32'd0);
      chk("rst_perf_drop", perf_drop_o, 32'd0);

      // Streaming with gnt=1: two instructions then one bubble (DEPTH=2)
      cyc(); rst_i = 1'b0; imem_gnt_i = 1'b1; mid();          // C0
      chk("c0_req", 32'(imem_req_o), 32'd1);
      chk("c0_addr", imem_addr_o, 32'h0);
      chk("c0_valid", 32'(valid_o), 32'd0);
      cyc(); mid();                                           // C1
      chk("c1_addr", imem_addr_o, 32'h4);
      chk("c1_valid", 32'(valid_o), 32'd0);
      cyc(); mid();                                           // C2
      chk_head("c2", 32'h0);
      chk("c2_req", 32'(imem_req_o), 32'd0);
      cyc(); mid();                                           // C3
      chk_head("c3", 32'h4);
      chk("c3_addr", imem_addr_o, 32'h8);
      cyc(); mid();                                           // C4
      chk_bubble("c4");
      cyc(); mid();                                           // C5
      chk_head("c5", 32'h8);
      cyc(); mid();                                           // C6
      chk_head("c6", 32'hC);

      // Stall for three cycles: req drops once both entries are allocated
      cyc(); stall_i = 1'b1; mid();                           // C7
      chk("c7_valid", 32'(valid_o), 32'd0);
      chk("c7_addr", imem_addr_o, 32'h14);
      cyc(); mid();                                           // C8
      chk("c8_req", 32'(imem_req_o), 32'd0);
      chk_head("c8", 32'h10);
      cyc(); mid();                                           // C9
      chk("c9_req", 32'(imem_req_o), 32'd0);
      chk_head("c9", 32'h10);
      cyc(); stall_i = 1'b0; mid();                           // C10
      chk_head("c10", 32'h10);
      cyc(); mid();                                           // C11
      chk_head("c11", 32'h14);
      chk("c11_addr", imem_addr_o, 32'h18);

      // gnt=0 for five cycles: request held, queue drains
      cyc(); imem_gnt_i = 1'b0; mid();                        // C12
      chk("c12_req", 32'(imem_req_o), 32'd1);
      chk("c12_addr", imem_addr_o, 32'h1C);
      cyc(); mid();                                           // C13
      chk_head("c13", 32'h18);
      cyc(); mid();                                           // C14
      chk_bubble("c14");
      chk("c14_addr", imem_addr_o, 32'h1C);
      cyc(); mid();                                           // C15
      cyc(); mid();                                           // C16
      chk("c16_req", 32'(imem_req_o), 32'd1);
      chk("c16_addr", imem_addr_o, 32'h1C);
      chk("c16_valid", 32'(valid_o), 32'd0);

      // Resume, then reset with entries in the queue
      cyc(); imem_gnt_i = 1'b1; mid();                        // C17
      chk("c17_addr", imem_addr_o, 32'h1C);
      cyc(); mid();                                           // C18
      chk("c18_addr", imem_addr_o, 32'h20);
      cyc(); mid();                                           // C19
      chk_head("c19", 32'h1C);
      cyc(); rst_i = 1'b1; mid();                             // C20
      chk("c20_req", 32'(imem_req_o), 32'd0);
      chk("c20_valid", 32'(valid_o), 32'd0);
      cyc(); rst_i = 1'b0; mid();                             // C21
      chk("c21_req", 32'(imem_req_o), 32'd1);
      chk("c21_addr", imem_addr_o, 32'h0);
      chk_bubble("c21");
      cyc(); mid();                                           // C22
      chk("c22_addr", imem_addr_o, 32'h4);
      cyc(); mid();                                           // C23
      chk_head("c23", 32'h0);

      // Two requests outstanding, then redirect to 0x103
      cyc(); rsp_en = 1'b0; mid();                            // C24
      chk_head("c24", 32'h4);
      chk("c24_addr", imem_addr_o, 32'h8);
      cyc(); mid();                                           // C25
      chk("c25_valid", 32'(valid_o), 32'd0);
      chk("c25_addr", imem_addr_o, 32'hC);
      cyc(); redirect_i = 1'b1; redirect_pc_i = 32'h103; mid(); // C26
      chk("c26_req", 32'(imem_req_o), 32'd0);
      chk("c26_valid", 32'(valid_o), 32'd0);
      cyc(); redirect_i = 1'b0; rsp_en = 1'b1; mid();         // C27: drop 0x8
      chk("c27_req", 32'(imem_req_o), 32'd1);
      chk("c27_addr", imem_addr_o, 32'h100);
      cyc(); mid();                                           // C28: drop 0xC
      chk("c28_addr", imem_addr_o, 32'h104);
      chk("c28_valid", 32'(valid_o), 32'd0);
      cyc(); mid();                                           // C29
      chk("c29_valid", 32'(valid_o), 32'd0);
      chk("c29_req", 32'(imem_req_o), 32'd0);
      cyc(); mid();                                           // C30
      chk_head("c30", 32'h100);

      // Redirect to the top of the address space: fetch wraps to 0
      cyc(); redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; mid(); // C31
      chk("c31_valid", 32'(valid_o), 32'd0);
      chk("c31_req", 32'(imem_req_o), 32'd0);
      cyc(); redirect_i = 1'b0; mid();                        // C32
      chk("c32_req", 32'(imem_req_o), 32'd1);
      chk("c32_addr", imem_addr_o, 32'hFFFF_FFFC);
      cyc(); mid();                                           // C33
      chk("c33_addr", imem_addr_o, 32'h0);
      cyc(); mid();                                           // C34
      chk_head("c34", 32'hFFFF_FFFC);
      cyc(); mid();                                           // C35
      chk_head("c35", 32'h0);
      chk("c35_addr", imem_addr_o, 32'h4);

      // Quiesce and check counters and the consumed stream
      cyc(); stall_i = 1'b1; imem_gnt_i = 1'b0; mid();        // C36
      chk("perf_stall", perf_stall_o, EXP_STALL);
      chk("perf_drop", perf_drop_o, EXP_DROP);
      #1;
      chk("stream_len", 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         chk($sformatf("stream_%0d", i), got_q[i], exp_q[i]);
      end

      // ---------------- report ----------------
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
